// File: rtl/ghffe_pkg.sv
// Shared sizing, return-pipeline tag and address packing for the metadata read path.
package ghffe_pkg;

    localparam int unsigned N_REQ  = 37;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PTR_W  = 10;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned ADDR_W = IDX_W + PTR_W;
    localparam int unsigned LINK_W = N_REQ * DATA_W;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [IDX_W-1:0] idx,
                                                    input logic [PTR_W-1:0] ptr);
        return {idx, ptr};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker: lowest requesting index at or after last+1, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             gnt_valid_c,
    output logic [IDX_W-1:0] gnt_idx_c
);

    int               pos;
    logic [IDX_W-1:0] cand;

    // Scan farthest-first so the nearest requester after last is the final assignment.
    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        pos         = 0;
        cand        = '0;
        for (int k = int'(N); k >= 1; k--) begin
            pos = int'(last) + k;
            if (pos >= int'(N)) pos = pos - int'(N);
            cand = IDX_W'(pos);
            if (req[cand]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/metadata_arbiter.sv
// Round-robin arbitration of per-stream metadata reads onto one memory port,
// with per-stream auto-incrementing pointers and per-stream return slots.
module metadata_arbiter
    import ghffe_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rewind,
    input  logic                pause,
    input  logic [N_REQ-1:0]    metadata_request,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [LINK_W-1:0]   metadata_link,
    output logic [N_REQ-1:0]    metadata_available,
    output logic                busy
);

    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [N_REQ-1:0]  avail_d;
    logic [PTR_W-1:0]  ptr_q [N_REQ];
    logic [PTR_W-1:0]  ptr_d [N_REQ];
    logic [IDX_W-1:0]  last_q, last_d;
    rd_tag_t           pipe_q [RD_LAT];
    rd_tag_t           pipe_d [RD_LAT];
    logic              mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [LINK_W-1:0] link_d;
    logic              busy_d;
    logic              gnt_valid_c;
    logic [IDX_W-1:0]  gnt_idx_c;
    rd_tag_t           ret;

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req         (pause ? '0 : pending_q),
        .last        (last_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Next state: grant, return landing, then new requests override both.
    always_comb begin
        pending_d  = pending_q;
        avail_d    = metadata_available;
        ptr_d      = ptr_q;
        last_d     = last_q;
        pipe_d     = pipe_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr;
        link_d     = metadata_link;
        ret        = pipe_q[RD_LAT-1];
        if (rewind) begin
            pending_d = '0;
            avail_d   = '0;
            last_d    = IDX_W'(N_REQ - 1);
            for (int i = 0; i < int'(N_REQ); i++) ptr_d[i] = '0;
            for (int k = 0; k < int'(RD_LAT); k++) pipe_d[k].valid = 1'b0;
        end else begin
            pipe_d[0] = '{valid: gnt_valid_c, idx: gnt_idx_c};
            for (int k = 1; k < int'(RD_LAT); k++) pipe_d[k] = pipe_q[k-1];
            if (gnt_valid_c) begin
                mem_rd_d             = 1'b1;
                mem_addr_d           = pack_addr(gnt_idx_c, ptr_q[gnt_idx_c]);
                pending_d[gnt_idx_c] = 1'b0;
                ptr_d[gnt_idx_c]     = ptr_q[gnt_idx_c] + PTR_W'(1);
                last_d               = gnt_idx_c;
            end
            if (ret.valid) begin
                link_d[ret.idx * DATA_W +: DATA_W] = mem_rdata;
                avail_d[ret.idx]                   = 1'b1;
            end
            pending_d = pending_d | metadata_request;
            avail_d   = avail_d & ~metadata_request;
        end
        busy_d = |pending_d;
        for (int k = 0; k < int'(RD_LAT); k++) busy_d = busy_d | pipe_d[k].valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q          <= '0;
            metadata_available <= '0;
            last_q             <= IDX_W'(N_REQ - 1);
            mem_rd             <= 1'b0;
            mem_addr           <= '0;
            metadata_link      <= '0;
            busy               <= 1'b0;
            for (int i = 0; i < int'(N_REQ); i++) ptr_q[i] <= '0;
            for (int k = 0; k < int'(RD_LAT); k++) pipe_q[k] <= '0;
        end else begin
            pending_q          <= pending_d;
            metadata_available <= avail_d;
            last_q             <= last_d;
            mem_rd             <= mem_rd_d;
            mem_addr           <= mem_addr_d;
            metadata_link      <= link_d;
            busy               <= busy_d;
            for (int i = 0; i < int'(N_REQ); i++) ptr_q[i] <= ptr_d[i];
            for (int k = 0; k < int'(RD_LAT); k++) pipe_q[k] <= pipe_d[k];
        end
    end

endmodule

// File: doc/metadata_arbiter.md
# metadata_arbiter

Arbitrates 37 metadata requesters in the score/controller path for a single shared metadata memory read port. Each requester pulses a request; the block issues the memory read with round-robin fairness, auto-increments that requester's stream pointer, and returns the 16-bit word on a per-requester slot of `metadata_link` with a matching `metadata_available` flag. It sits between the scoring block's request vector and the note-data RAM loaded by the controller block.

## Interface
- `N_REQ`, 37: number of requesters/streams
- `DATA_W`, 16: metadata word width
- `PTR_W`, 10: per-stream word pointer width (1024 words/stream)
- `RD_LAT`, 2: fixed memory read latency in cycles (>=1)
- `clk`  in  1  system clock (100 MHz domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `rewind`  in  1  synchronous song restart: clears pointers, pending, available
- `pause`  in  1  when high, no new reads issued; in-flight reads complete
- `metadata_request`  in  N_REQ  per-requester request, sampled each edge
- `mem_rd`  out  1  read strobe, one cycle per read
- `mem_addr`  out  6+PTR_W  `{req_index, ptr}`: index*2^PTR_W + ptr
- `mem_rdata`  in  DATA_W  valid RD_LAT cycles after the `mem_rd` cycle
- `metadata_link`  out  N_REQ*DATA_W  slot i = bits [i*DATA_W +: DATA_W]
- `metadata_available`  out  N_REQ  slot i holds data for i's latest request
- `busy`  out  1  any pending request or read in flight

## Operation
- Per requester: `pending[i]`, `avail[i]`, `ptr[i]` (PTR_W), data slot.
- Request edge with `metadata_request[i]`=1: `pending[i]`<=1, `avail[i]`<=0. Request while already pending: coalesced (no extra read).
- Arbiter: if `!pause` and any pending, grant lowest index at or after `last_grant+1`, wrapping modulo N_REQ; one grant per cycle. At grant edge: `mem_rd`<=1, `mem_addr`<={i, ptr[i]}, `pending[i]`<=0, `ptr[i]`<=ptr[i]+1 (wraps 2^PTR_W-1 -> 0), `last_grant`<=i.
- Return pipeline: RD_LAT-deep shift of {valid, index}. On exit with valid: slot[index]<=`mem_rdata`, `avail[index]`<=1.
- Return and new request for same i on one edge: slot written, `avail[i]`<=0, `pending[i]`<=1 (request wins).
- Grant cannot hit a requester with a read in flight unless it re-requested; both reads return in order, each setting avail.
- `rewind`: all pending, avail, ptr, `last_grant` (to N_REQ-1) cleared; pipeline valids cleared (in-flight data discarded); `mem_rd`<=0; requests on the rewind edge dropped; slot data retained.
- `busy` = |pending | any pipeline valid.

## Timing
- Reset (`reset_n` low): `mem_rd`=0, `mem_addr`=0, `metadata_link`=0, `metadata_available`=0, `busy`=0, ptrs 0, `last_grant`=N_REQ-1.
- Uncontested latency: request sampled at edge E0 -> `mem_rd` high after E1 -> avail high after E1+RD_LAT (3 cycles with RD_LAT=2).
- Throughput: one read per cycle; worst-case wait N_REQ-1 grants when all pending.
- All outputs registered; `mem_rd` is a single-cycle pulse per grant.
- `pause` high at edge: no grant on that edge; returns still land.

## Structure
- Shared package `ghffe_pkg`: N_REQ, DATA_W, PTR_W, metadata address-field widths, `{index,ptr}` pack function.
- One sub-module: `rr_arbiter` (N-way round-robin, inputs req vector + last grant, outputs grant valid/index); rest in `metadata_arbiter`.

## Test plan
- Reset, single request i=5 -> `mem_rd` 1 cycle later with `mem_addr`=5*1024+0; `avail[5]` 3 cycles after request; slot 5 = returned word; second request -> addr 5*1024+1.
- Requests 0, 36, 17 same edge, last_grant=N_REQ-1 -> grants 0, 17, 36 on consecutive cycles; next simultaneous 0 and 36 after last=36 -> 0 first.
- Drive ptr[3] to 1023, request -> addr 3*1024+1023, next request -> 3*1024+0.
- `pause` high with 4 pending -> `mem_rd` stays 0, `busy`=1; release -> 4 consecutive grants.
- Rewind while 2 reads in flight -> no avail set for them; ptrs 0; subsequent request i=2 -> addr 2*1024+0.
- Request i=7 on same edge its previous read returns -> slot updated, `avail[7]`=0, new read issued next cycle; `reset_n` low mid-read -> all outputs to reset values immediately.
